// File: rtl/sigmoid_pkg.sv
// ============================================================================
// sigmoid_pkg : Q8.24 constants, segment tables and FSM states for sigmoid_eval
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sigmoid_pkg;

    localparam int          FRAC    = 24;
    localparam logic [31:0] ONE     = 32'h0100_0000;
    localparam logic [31:0] HALF    = 32'h0080_0000;
    localparam logic [2:0]  SEG_SAT = 3'd6;

    // Lower edge of each segment; anything at or beyond SEG_BOUND[6] is saturated.
    localparam logic [31:0] SEG_BOUND [0:6] = '{
        32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000,
        32'h0400_0000, 32'h0500_0000, 32'h0600_0000
    };

    // Expansion point of each segment's polynomial (entry 7 is never selected).
    localparam logic [31:0] XC_TABLE [0:7] = '{
        32'h0000_0000, 32'h0180_0000, 32'h0280_0000, 32'h0380_0000,
        32'h0500_0000, 32'h0500_0000, 32'h0000_0000, 32'h0000_0000
    };

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEG  = 3'd1,
        S_MUL1 = 3'd2,
        S_MUL2 = 3'd3,
        S_SUM  = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seg_encode.sv
// ============================================================================
// seg_encode : maps a non-negative Q8.24 magnitude to its segment code 0..6
// Revision   : 1.0
// ============================================================================
`default_nettype none

module seg_encode
    import sigmoid_pkg::*;
#(
    parameter int DWIDTH = 32
)
(
    input  logic [DWIDTH-1:0] a_i,
    output logic [2:0]        seg_o
);

    always_comb begin
        seg_o = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            if (a_i >= DWIDTH'(SEG_BOUND[k])) begin
                seg_o = 3'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sigmoid_eval.sv
// ============================================================================
// sigmoid_eval : piecewise-polynomial sigmoid in Q8.24, one shared multiplier.
//                Define SIGMOID_TERM2_EN for the second-order term (extra cycle).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module sigmoid_eval
    import sigmoid_pkg::*;
#(
    parameter int DWIDTH = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] x_in,
    output logic [2:0]        seg,
    input  logic [DWIDTH-1:0] c0,
    input  logic [DWIDTH-1:0] c1,
    input  logic [DWIDTH-1:0] c2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] y_out
);

    localparam logic [DWIDTH-1:0] C_ONE     = DWIDTH'(ONE);
    localparam logic [DWIDTH-1:0] C_MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] C_MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                sign_q, sign_d;
    logic [DWIDTH-1:0]   a_q, a_d;
    logic [2:0]          seg_q, seg_d;
    logic [DWIDTH-1:0]   c0_q, c0_d;
    logic [DWIDTH-1:0]   c1_q, c1_d;
    logic [DWIDTH-1:0]   d_q, d_d;
    logic [DWIDTH-1:0]   p_q, p_d;
    logic [DWIDTH-1:0]   y_q, y_d;

    logic [DWIDTH-1:0]   w_abs;
    logic [2:0]          w_seg;
    logic [DWIDTH-1:0]   w_mul_a;
    logic [2*DWIDTH-1:0] w_prod;
    logic [DWIDTH-1:0]   w_p;
    logic [DWIDTH-1:0]   w_yp_raw;
    logic [DWIDTH-1:0]   w_yp;
    logic                w_unused_prod;

    // The most negative input has no positive twin; pin it to the largest magnitude.
    assign w_abs = !x_in[DWIDTH-1]   ? x_in      :
                   (x_in == C_MIN_NEG) ? C_MAX_POS : (~x_in + 1'b1);

    seg_encode #(
        .DWIDTH (DWIDTH)
    ) u_seg_encode (
        .a_i   (w_abs),
        .seg_o (w_seg)
    );

`ifdef SIGMOID_TERM2_EN
    logic [DWIDTH-1:0] c2_q, c2_d;

    always_comb begin
        w_mul_a = c1_q + p_q;
        if (state_q == S_MUL1) begin
            w_mul_a = c2_q;
        end
    end
`else
    logic w_unused_c2;

    assign w_unused_c2 = ^c2;
    assign w_mul_a     = c1_q;
`endif

    assign w_prod        = $signed(w_mul_a) * $signed(d_q);
    assign w_p           = w_prod[DWIDTH+FRAC-1:FRAC];
    assign w_unused_prod = ^{w_prod[2*DWIDTH-1:DWIDTH+FRAC], w_prod[FRAC-1:0]};

    assign w_yp_raw = (seg_q == SEG_SAT) ? C_ONE : (c0_q + p_q);
    assign w_yp     = w_yp_raw[DWIDTH-1]  ? '0    :
                      (w_yp_raw > C_ONE)  ? C_ONE : w_yp_raw;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        a_d     = a_q;
        seg_d   = seg_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
`ifdef SIGMOID_TERM2_EN
        c2_d    = c2_q;
`endif
        d_d     = d_q;
        p_d     = p_q;
        y_d     = y_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = x_in[DWIDTH-1];
                    a_d     = w_abs;
                    seg_d   = w_seg;
                    state_d = S_SEG;
                end
            end
            S_SEG: begin
                c0_d = c0;
                c1_d = c1;
                d_d  = a_q - DWIDTH'(XC_TABLE[seg_q]);
`ifdef SIGMOID_TERM2_EN
                c2_d    = c2;
                state_d = S_MUL1;
`else
                state_d = S_MUL2;
`endif
            end
            S_MUL1: begin
                p_d     = w_p;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                p_d     = w_p;
                state_d = S_SUM;
            end
            S_SUM: begin
                y_d     = sign_q ? (C_ONE - w_yp) : w_yp;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags are registered so both read 0 throughout reset.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            a_q         <= '0;
            seg_q       <= 3'd0;
            c0_q        <= '0;
            c1_q        <= '0;
`ifdef SIGMOID_TERM2_EN
            c2_q        <= '0;
`endif
            d_q         <= '0;
            p_q         <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            a_q         <= a_d;
            seg_q       <= seg_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
`ifdef SIGMOID_TERM2_EN
            c2_q        <= c2_d;
`endif
            d_q         <= d_d;
            p_q         <= p_d;
            y_q         <= y_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign seg       = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_eval.sv
// ============================================================================
// tb_sigmoid_eval : scoreboard bench for sigmoid_eval with a Q8.24 reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sigmoid_eval;

    localparam logic [31:0] ONE = 32'h0100_0000;
`ifdef SIGMOID_TERM2_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        logic [31:0] y;
        logic [2:0]  s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] x_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [2:0]  seg;
    logic [31:0] y_out;
    logic [31:0] c0, c1, c2;

    logic [31:0] c0_tab [0:7];
    logic [31:0] c1_tab [0:7];
    logic [31:0] c2_tab [0:7];

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    bit   rand_rdy = 1'b0;
    int   since = -1;
    bit   seen = 1'b1;

    assign c0 = c0_tab[seg];
    assign c1 = c1_tab[seg];
    assign c2 = c2_tab[seg];

    sigmoid_eval #(
        .DWIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .seg       (seg),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: fixed-point products floor-divided by 2^24, 32-bit wrapping sums.
    function automatic int mulq(input int u, input int v);
        longint pr;
        pr = longint'(u) * longint'(v);
        return int'(pr >>> 24);
    endfunction

    function automatic exp_t model(input logic [31:0] x);
        exp_t   e;
        int     xi, d, p, yp, s;
        int     c0v, c1v, c2v;
        longint a;
        int     xc_halves [0:6] = '{0, 3, 5, 7, 10, 10, 0};
        xi = x;
        a  = xi;
        if (a < 0) a = -a;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        s  = (a >= 6 * 64'sd16777216) ? 6 : int'(a / 64'sd16777216);
        d  = int'(a - longint'(xc_halves[s]) * 64'sd8388608);
        c0v = c0_tab[s];
        c1v = c1_tab[s];
        c2v = c2_tab[s];
`ifdef SIGMOID_TERM2_EN
        p = mulq(c2v, d);
        p = mulq(c1v + p, d);
`else
        p = mulq(c1v, d);
`endif
        yp = (s == 6) ? int'(ONE) : c0v + p;
        if (yp < 0) yp = 0;
        else if (yp > int'(ONE)) yp = int'(ONE);
        e.y = x[31] ? (ONE - 32'(yp)) : 32'(yp);
        e.s = 3'(s);
        return e;
    endfunction

    task automatic load_default_tables();
        c0_tab = '{32'h0080_0000, 32'h00D1_4000, 32'h00EC_2000, 32'h00F8_4000,
                   32'h00FE_4000, 32'h00FE_4000, 32'hDEAD_BEEF, 32'h0000_0000};
        c1_tab = '{32'h0040_0000, 32'h0026_2000, 32'h000F_2000, 32'h0005_6000,
                   32'h0001_0000, 32'h0001_0000, 32'h1234_5678, 32'h0000_0000};
        c2_tab = '{32'h0000_0000, 32'hFFF1_C000, 32'hFFFA_0000, 32'hFFFE_0000,
                   32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
    endtask

    task automatic load_random_tables();
        for (int k = 0; k < 8; k++) begin
            c0_tab[k] = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0100_0000;
            c1_tab[k] = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
            c2_tab[k] = 32'($urandom_range(0, 32'h0100_0000)) - 32'h0080_0000;
        end
    endtask

    task automatic send(input logic [31:0] x);
        exp_t e;
        int   n;
        e = model(x);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x_in     = x;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        else sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            since = -1;
            seen  = 1'b1;
        end else begin
            if (since >= 0) since++;
            if (out_valid) begin
                check("no_accept_in_done", {31'd0, in_ready}, 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", 32'(since), 32'(LAT));
                end
                if (out_ready) begin
                    check("output_expected", {31'd0, sb_q.size() != 0}, 32'd1);
                    if (sb_q.size() != 0) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("y_out", y_out, e.y);
                        check("seg", {29'd0, seg}, {29'd0, e.s});
                    end
                end
            end
            if (in_valid && in_ready) begin
                since = 0;
                seen  = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] y_hold;
        int          n;
        logic [31:0] dir_x [0:5] = '{32'h0000_0000, 32'h0800_0000, 32'hF800_0000,
                                      32'h0180_0000, 32'hFE80_0000, 32'h8000_0000};

        load_default_tables();
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y_out", y_out, 32'd0);
        check("rst_seg", {29'd0, seg}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        foreach (dir_x[i]) send(dir_x[i]);
        drain();

        // Back-pressure: result must freeze while downstream stalls.
        out_ready = 1'b0;
        send(32'h00C0_0000);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_rise", {31'd0, out_valid}, 32'd1);
        y_hold = y_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_y_hold", y_out, y_hold);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_single_xfer", {31'd0, out_valid}, 32'd0);
        check("stall_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset while the multiplier is busy with the final product.
        send(32'h0230_0000);
        repeat (LAT - 3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready_rel", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        end
        send(32'hFD40_0000);
        drain();

        for (int r = 0; r < 3; r++) begin
            load_random_tables();
            rand_rdy = 1'b1;
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 3) == 0) send($urandom);
                else send(32'($urandom_range(0, 32'h0E00_0000)) - 32'h0700_0000);
            end
            drain();
            rand_rdy = 1'b0;
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end

        load_default_tables();
        send(32'h8000_0000);
        send(32'h0600_0000);
        send(32'h05FF_FFFF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
